hue_rgb_mapper: RTL and testbench

HUE_RGB_MAPPER -- requirements
Module: hue_rgb_mapper

---
 rtl/hue_rgb_mapper.sv | 108 ++++++++++
 tb/tb_hue_rgb_mapper.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hue_rgb_mapper.sv
// hue_rgb_mapper: pipelined hue+amplitude to RGB colour, optional gamma stage under HUE_RGB_GAMMA_EN.
module hue_rgb_mapper #(
  parameter int D       = 10,
  parameter int A       = 8,
  parameter int AMP_MIN = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [D-1:0] noteHue_i,
  input  logic [A-1:0] noteAmp_i,
  input  logic         start,
  input  logic         last_i,
  output logic [7:0]   red_o,
  output logic [7:0]   green_o,
  output logic [7:0]   blue_o,
  output logic         data_v,
  output logic         frameDone_o
);
  localparam logic [D:0] K1 = (D+1)'(341);
  localparam logic [D:0] K2 = (D+1)'(682);
  localparam logic [D:0] K3 = (D+1)'(1023);

  function automatic logic [7:0] scale(input logic [7:0] a, input logic [7:0] b);
    return 8'(({8'b0, a} * {8'b0, b}) >> 8);
  endfunction

  logic [7:0] amp8;
  generate
    if (A >= 8) begin : g_amp_wide
      assign amp8 = noteAmp_i[A-1 -: 8];
    end else begin : g_amp_narrow
      assign amp8 = 8'(noteAmp_i);
    end
  endgenerate

  logic [D:0] h;
  logic [7:0] ramp;
  logic       v1_q, l1_q, v2_q, l2_q, v3_q, l3_q;
  logic [1:0] sec_d, sec_q;
  logic [8:0] pos_d, pos_q;
  logic [7:0] amp1_d, amp1_q, amp2_q;
  logic [7:0] r2_d, g2_d, b2_d, r2_q, g2_q, b2_q;
  logic [7:0] r3_q, g3_q, b3_q;

  // Amplitude gating folds into a zero scale factor so stage 3 emits black.
  always_comb begin
    h      = {1'b0, noteHue_i};
    sec_d  = (h >= K3) ? 2'd0 : (h >= K2) ? 2'd2 : (h >= K1) ? 2'd1 : 2'd0;
    pos_d  = (h >= K3) ? 9'd0 : 9'((h >= K2) ? h - K2 : (h >= K1) ? h - K1 : h);
    amp1_d = (int'(noteAmp_i) < AMP_MIN) ? 8'd0 : amp8;
    ramp   = 8'(({1'b0, pos_q} + {pos_q, 1'b0}) >> 2);
    r2_d   = (sec_q == 2'd0) ? ~ramp : (sec_q == 2'd2) ? ramp : 8'd0;
    g2_d   = (sec_q == 2'd0) ? ramp : (sec_q == 2'd1) ? ~ramp : 8'd0;
    b2_d   = (sec_q == 2'd1) ? ramp : (sec_q == 2'd2) ? ~ramp : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1_q, l1_q, v2_q, l2_q, v3_q, l3_q} <= '0;
      {sec_q, pos_q, amp1_q, amp2_q}       <= '0;
      {r2_q, g2_q, b2_q, r3_q, g3_q, b3_q} <= '0;
    end else begin
      v1_q   <= start;
      l1_q   <= start & last_i;
      sec_q  <= sec_d;
      pos_q  <= pos_d;
      amp1_q <= amp1_d;
      v2_q   <= v1_q;
      l2_q   <= l1_q;
      r2_q   <= r2_d;
      g2_q   <= g2_d;
      b2_q   <= b2_d;
      amp2_q <= amp1_q;
      v3_q   <= v2_q;
      l3_q   <= l2_q;
      if (v2_q) begin
        r3_q <= scale(r2_q, amp2_q);
        g3_q <= scale(g2_q, amp2_q);
        b3_q <= scale(b2_q, amp2_q);
      end
    end
  end

`ifdef HUE_RGB_GAMMA_EN
  logic       v4_q, l4_q;
  logic [7:0] r4_q, g4_q, b4_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v4_q, l4_q, r4_q, g4_q, b4_q} <= '0;
    end else begin
      v4_q <= v3_q;
      l4_q <= l3_q;
      if (v3_q) begin
        r4_q <= scale(r3_q, r3_q);
        g4_q <= scale(g3_q, g3_q);
        b4_q <= scale(b3_q, b3_q);
      end
    end
  end
  assign {red_o, green_o, blue_o} = {r4_q, g4_q, b4_q};
  assign data_v      = v4_q;
  assign frameDone_o = l4_q;
`else
  assign {red_o, green_o, blue_o} = {r3_q, g3_q, b3_q};
  assign data_v      = v3_q;
  assign frameDone_o = l3_q;
`endif
endmodule

// File: tb/tb_hue_rgb_mapper.sv
// tb_hue_rgb_mapper: scoreboard bench for hue_rgb_mapper (latency 3, or 4 with HUE_RGB_GAMMA_EN).
module tb_hue_rgb_mapper;
`ifdef HUE_RGB_GAMMA_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 0, rst = 1, start = 0, last_i = 0;
  logic [9:0] noteHue_i = '0;
  logic [7:0] noteAmp_i = '0;
  logic [7:0] red_o, green_o, blue_o;
  logic       data_v, frameDone_o;

  hue_rgb_mapper dut (
    .clk(clk), .rst(rst), .noteHue_i(noteHue_i), .noteAmp_i(noteAmp_i),
    .start(start), .last_i(last_i), .red_o(red_o), .green_o(green_o),
    .blue_o(blue_o), .data_v(data_v), .frameDone_o(frameDone_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          tests = 0, fails = 0, cyc = 0;
  logic [23:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] model(input int hue, input int amp);
    int pos, ramp, r, g, b;
    if (hue == 1023) begin
      pos = 0; r = 255; g = 0; b = 0;
    end else if (hue < 341) begin
      pos = hue; ramp = pos * 3 / 4; r = 255 - ramp; g = ramp; b = 0;
    end else if (hue < 682) begin
      pos = hue - 341; ramp = pos * 3 / 4; r = 0; g = 255 - ramp; b = ramp;
    end else begin
      pos = hue - 682; ramp = pos * 3 / 4; r = ramp; g = 0; b = 255 - ramp;
    end
    if (amp < 8) amp = 0;
    r = r * amp / 256; g = g * amp / 256; b = b * amp / 256;
`ifdef HUE_RGB_GAMMA_EN
    r = r * r / 256; g = g * g / 256; b = b * b / 256;
`endif
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic send(input int hue, input int amp, input logic last);
    exp_t e;
    e.rgb = model(hue, amp);
    e.last = last;
    e.cyc = cyc + LAT;
    q.push_back(e);
    start = 1; noteHue_i = 10'(hue); noteAmp_i = 8'(amp); last_i = last;
    @(posedge clk); #1;
    start = 0; last_i = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held = '0;
    end else if (data_v) begin
      if (q.size() == 0) chk("spurious_data_v", 32'(data_v), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", cyc, e.cyc);
        chk("rgb", {8'd0, red_o, green_o, blue_o}, {8'd0, e.rgb});
        chk("frameDone", 32'(frameDone_o), 32'(e.last));
        held = e.rgb;
      end
    end else begin
      chk("hold_rgb", {8'd0, red_o, green_o, blue_o}, {8'd0, held});
      chk("frameDone_idle", 32'(frameDone_o), 32'd0);
    end
  end

  initial begin
    #1;
    chk("reset_rgb", {8'd0, red_o, green_o, blue_o}, 32'd0);
    chk("reset_flags", {30'd0, data_v, frameDone_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    send(0, 255, 0);
    repeat (5) @(posedge clk);
    #1;
    send(341, 255, 0);
    send(1023, 255, 0);
    send(170, 128, 0);
    send(500, 7, 0);
    repeat (4) @(posedge clk);
    #1;
    send(100, 200, 0);
    send(400, 150, 0);
    send(700, 90, 0);
    send(1000, 255, 1);
    start = 0; last_i = 1;
    @(posedge clk); #1;
    last_i = 0;
    send(340, 255, 0);
    send(681, 8, 0);
    send(682, 255, 0);
    send(1022, 64, 1);
    for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    repeat (LAT + 2) @(posedge clk);
    #1;
    send(100, 200, 0);
    send(900, 255, 1);
    #1 rst = 1;
    #1;
    chk("rst_async_rgb", {8'd0, red_o, green_o, blue_o}, 32'd0);
    chk("rst_async_flags", {30'd0, data_v, frameDone_o}, 32'd0);
    @(negedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    send(0, 255, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
